// File: rtl/mreg_io_stream.sv
// IO sequencer between the external data port and the matrix register file.
// One io_inst per transaction: optional row-stream write, then optional buffered (transposable) read-out.
module mreg_io_stream #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int RAW   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              io_valid,
  output logic                              io_ready,
  input  logic [31:0]                       io_inst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*DW-1:0]               data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DW-1:0]               data_out,
  output logic                              busy,
  output logic                              rf_we,
  output logic [RAW-1:0]                    rf_waddr,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] rf_wrow,
  output logic [LANES*DW-1:0]               rf_wdata,
  output logic [RAW-1:0]                    rf_raddr,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] rf_rrow,
  input  logic [LANES*DW-1:0]               rf_rdata
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + 1);
  localparam int W  = LANES * DW;
  localparam bit TP = (ROWS == LANES);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_FETCH, S_EMIT} state_t;

  state_t          state, state_n;
  logic [RAW-1:0]  wr_reg, rd_reg;
  logic            tr;
  logic [RW-1:0]   wrow, ecnt, eidx;
  logic [FW-1:0]   fcnt;
  logic [W-1:0]    buffer [ROWS];
  logic [W-1:0]    beat;
  logic [RAW-1:0]  wr_f, rd_f;

  assign wr_f = RAW'(io_inst[23:20]);
  assign rd_f = RAW'(io_inst[19:16]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (io_valid) begin
          if (wr_f != '0)      state_n = S_WR;
          else if (rd_f != '0) state_n = S_FETCH;
        end
      end
      S_WR: begin
        if (in_valid && wrow == RW'(ROWS - 1))
          state_n = (rd_reg != '0) ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        if (fcnt == FW'(ROWS)) state_n = S_EMIT;
      end
      S_EMIT: begin
        if (out_valid && out_ready && ecnt == RW'(ROWS - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign io_ready = (state == S_IDLE);
  assign in_ready = (state == S_WR);
  assign busy     = (state != S_IDLE);
  // Gated by rst so the cycle in which reset is asserted cannot add a row.
  assign rf_we    = (state == S_WR) && in_valid && !rst;
  assign rf_waddr = wr_reg;
  assign rf_wrow  = wrow;
  assign rf_wdata = data_in;
  assign rf_raddr = rd_reg;
  assign rf_rrow  = (state == S_FETCH && fcnt != FW'(ROWS)) ? RW'(fcnt) : '0;

  // Next beat to load: current index before first presentation, else the following one.
  always_comb begin
    beat = '0;
    eidx = out_valid ? RW'(ecnt + 1'b1) : ecnt;
    if (TP && tr) begin
      for (int unsigned j = 0; j < LANES && j < ROWS; j++)
        beat[j*DW +: DW] = buffer[j][eidx*DW +: DW];
    end else begin
      beat = buffer[eidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg    <= '0;
      rd_reg    <= '0;
      tr        <= 1'b0;
      wrow      <= '0;
      fcnt      <= '0;
      ecnt      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_valid) begin
            wr_reg <= wr_f;
            rd_reg <= rd_f;
            tr     <= io_inst[24];
          end
        end
        S_WR: begin
          if (in_valid) wrow <= (wrow == RW'(ROWS - 1)) ? '0 : RW'(wrow + 1'b1);
        end
        S_FETCH: begin
          fcnt <= (fcnt == FW'(ROWS)) ? '0 : FW'(fcnt + 1'b1);
        end
        S_EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            data_out  <= beat;
          end else if (out_ready) begin
            if (ecnt == RW'(ROWS - 1)) begin
              ecnt      <= '0;
              out_valid <= 1'b0;
            end else begin
              ecnt     <= RW'(ecnt + 1'b1);
              data_out <= beat;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data for row k arrives while fcnt == k+1.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && fcnt != '0)
      buffer[RW'(fcnt - 1'b1)] <= rf_rdata;
  end

endmodule
